// File: rtl/unary_burst_expander.sv
// -----------------------------------------------------------------------------
// unary_burst_expander
//
// Purpose:
//   Turns a binary count into a burst of unary thermometer beats. Each beat
//   carries up to N ones, with the low lanes filled first. The ones summed over
//   every beat of one transaction equal the accepted count. A count of zero
//   still produces exactly one (empty, last) beat. A count that is an exact
//   multiple of N ends on a full beat, with no trailing empty beat.
//
// Parameters:
//   N   lanes per beat (N >= 2)
//   CW  width of in_count / remaining counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer presents in_count
//   in_ready   block can take a count this cycle (held low during reset)
//   in_count   binary count to expand
//   out_valid  a beat is presented
//   out_ready  consumer takes the beat
//   out_lanes  thermometer beat, bit 0 filled first
//   out_sum    number of ones in out_lanes
//   out_last   final beat of the transaction
//   busy       a transaction is being emitted
//
// Configuration:
//   UNARY_SKID_EN  When defined, a one-entry pending register lets a new count
//                  be accepted while a burst is still being emitted. The next
//                  burst then starts on the cycle right after the last beat,
//                  with no bubble. When undefined, counts are only accepted in
//                  IDLE, so one out_valid=0 cycle separates transactions.
// -----------------------------------------------------------------------------
module unary_burst_expander #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CW-1:0]            in_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_lanes,
  output logic [$clog2(N+1)-1:0]   out_sum,
  output logic                     out_last,
  output logic                     busy
);

  localparam int SW = $clog2(N+1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   remaining_q;
  logic [CW-1:0]   remaining_d;

`ifdef UNARY_SKID_EN
  logic            pend_vld_q;
  logic            pend_vld_d;
  logic [CW-1:0]   pend_cnt_q;
  logic [CW-1:0]   pend_cnt_d;
`endif

  logic [SW-1:0]   beat_ones;
  logic [N-1:0]    beat_lanes;
  logic            beat_last;
  logic            beat_xfer;
  logic            accept;

  // State register. Reset drops any beat in flight: with state back in IDLE
  // the beat outputs are forced low immediately, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
`ifdef UNARY_SKID_EN
      pend_vld_q  <= 1'b0;
      pend_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
`ifdef UNARY_SKID_EN
      pend_vld_q  <= pend_vld_d;
      pend_cnt_q  <= pend_cnt_d;
`endif
    end
  end

  // Beat decode from the registered remaining count. The comparison is done
  // at 32 bits so it stays correct whichever of N or 2**CW-1 is larger.
  always_comb begin
    beat_last  = (32'(remaining_q) <= 32'(N));
    beat_ones  = beat_last ? SW'(remaining_q) : SW'(N);
    beat_lanes = '0;
    for (int i = 0; i < N; i++) begin
      beat_lanes[i] = (i < int'(beat_ones));
    end
  end

  // Next-state logic. A beat that is not the last one only shrinks remaining;
  // the subtraction cannot wrap because beat_ones never exceeds remaining.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
`ifdef UNARY_SKID_EN
    pend_vld_d  = pend_vld_q;
    pend_cnt_d  = pend_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          remaining_d = in_count;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (beat_xfer && !beat_last) begin
          remaining_d = remaining_q - CW'(beat_ones);
        end else if (beat_xfer) begin
`ifdef UNARY_SKID_EN
          // Chain straight into the next burst: the pending count first,
          // otherwise a count arriving this very cycle bypasses pending.
          if (pend_vld_q) begin
            remaining_d = pend_cnt_q;
            pend_vld_d  = 1'b0;
          end else if (accept) begin
            remaining_d = in_count;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
`ifdef UNARY_SKID_EN
        // A count accepted mid-burst waits in the pending slot, unless it was
        // already loaded directly by the last-beat bypass above.
        if (accept && !(beat_xfer && beat_last)) begin
          pend_vld_d = 1'b1;
          pend_cnt_d = in_count;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic. in_ready is gated by rst_n so nothing is taken while reset
  // is held; the beat outputs only show a value while in EMIT.
  always_comb begin
    busy      = (state_q == EMIT);
    out_valid = (state_q == EMIT);
    out_lanes = (state_q == EMIT) ? beat_lanes : '0;
    out_sum   = (state_q == EMIT) ? beat_ones : '0;
    out_last  = (state_q == EMIT) ? beat_last : 1'b0;
`ifdef UNARY_SKID_EN
    in_ready  = rst_n && !pend_vld_q;
`else
    in_ready  = rst_n && (state_q == IDLE);
`endif
    accept    = in_valid && in_ready;
    beat_xfer = out_valid && out_ready;
  end

endmodule

// File: tb/tb_unary_burst_expander.sv
// -----------------------------------------------------------------------------
// tb_unary_burst_expander
//
// Self-checking bench for unary_burst_expander at N=4, CW=4. Inputs are driven
// and outputs sampled on the falling edge. Expected beats come from a small
// reference model that splits each count into chunks of at most N ones.
// -----------------------------------------------------------------------------
module tb_unary_burst_expander;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int SW = $clog2(N+1);

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [CW-1:0]   in_count;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_lanes;
  logic [SW-1:0]   out_sum;
  logic            out_last;
  logic            busy;

  typedef struct packed {
    logic [N-1:0]  lanes;
    logic [SW-1:0] sum;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    prod_q[$];
  int    checks   = 0;
  int    failures = 0;

  unary_burst_expander #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lanes (out_lanes),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a count becomes ceil(count/N) beats of min(left, N)
  // ones each, and a zero count becomes one empty last beat.
  task automatic model_push(input int c);
    int    left;
    int    o;
    beat_t b;
    if (c == 0) begin
      b.lanes = '0;
      b.sum   = '0;
      b.last  = 1'b1;
      exp_q.push_back(b);
    end else begin
      left = c;
      while (left > 0) begin
        o       = (left < N) ? left : N;
        b.lanes = N'((1 << o) - 1);
        b.sum   = SW'(o);
        b.last  = (left <= N);
        exp_q.push_back(b);
        left    = left - o;
      end
    end
  endtask

  // Runs every count in prod_q through the DUT, comparing each transferred
  // beat with the model. gaps counts out_valid=0 cycles seen after the first
  // beat while work is still outstanding.
  task automatic run_stream(input int stall_pct, input int budget, output int gaps);
    int    cyc;
    bit    started;
    bit    prev_hold;
    beat_t prev;
    beat_t cur;
    beat_t e;
    cyc       = 0;
    started   = 1'b0;
    prev_hold = 1'b0;
    prev      = '0;
    gaps      = 0;
    while ((prod_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      in_valid  = (prod_q.size() > 0);
      in_count  = in_valid ? CW'(prod_q[0]) : '0;
      out_ready = ($urandom_range(99) >= stall_pct);
      cur       = '{out_lanes, out_sum, out_last};
      if (prev_hold) begin
        checks++;
        if (!out_valid || cur !== prev) begin
          failures++;
          $display("[TB] FAIL hold_stable: got valid=%b beat=%b/%0d/%b expected valid=1 beat=%b/%0d/%b",
                   out_valid, cur.lanes, cur.sum, cur.last, prev.lanes, prev.sum, prev.last);
        end
      end
      if (out_valid) begin
        started = 1'b1;
        if (out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL extra_beat: got beat=%b/%0d/%b expected no beat",
                     cur.lanes, cur.sum, cur.last);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              failures++;
              $display("[TB] FAIL beat: got %b/%0d/%b expected %b/%0d/%b",
                       cur.lanes, cur.sum, cur.last, e.lanes, e.sum, e.last);
            end
          end
        end
      end else if (started) begin
        gaps++;
      end
      prev_hold = out_valid && !out_ready;
      prev      = cur;
      if (in_valid && in_ready) begin
        model_push(prod_q.pop_front());
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (prod_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL stream_timeout: got %0d counts and %0d beats outstanding expected 0 and 0",
               prod_q.size(), exp_q.size());
    end
    prod_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_count  = '0;
    out_ready = 1'b0;
    #12;
    checks++;
    if ({out_valid, in_ready, busy, out_last, out_lanes, out_sum} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got valid=%b ready=%b busy=%b last=%b lanes=%b sum=%0d expected all zero",
               out_valid, in_ready, busy, out_last, out_lanes, out_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: got ready=%b valid=%b expected ready=1 valid=0",
               in_ready, out_valid);
    end
  endtask

  // One-beat count: the beat must appear exactly one cycle after accept and
  // busy must fall once it transfers.
  task automatic test_single(input int c);
    beat_t e;
    beat_t cur;
    exp_q.delete();
    model_push(c);
    e = exp_q.pop_front();
    @(negedge clk);
    in_valid  = 1'b1;
    in_count  = CW'(c);
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    cur      = '{out_lanes, out_sum, out_last};
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || cur !== e) begin
      failures++;
      $display("[TB] FAIL single_beat(%0d): got valid=%b busy=%b beat=%b/%0d/%b expected valid=1 busy=1 beat=%b/%0d/%b",
               c, out_valid, busy, cur.lanes, cur.sum, cur.last, e.lanes, e.sum, e.last);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_done(%0d): got valid=%b busy=%b expected 0 0", c, out_valid, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_multi_beat();
    int g;
    prod_q.push_back(9);
    run_stream(0, 30, g);
  endtask

  // Count 15 with the consumer stalling 5 cycles on beat 2.
  task automatic test_stall();
    int    idx;
    int    stall;
    int    cyc;
    beat_t e;
    beat_t cur;
    exp_q.delete();
    @(negedge clk);
    in_valid  = 1'b1;
    in_count  = CW'(15);
    out_ready = 1'b1;
    model_push(15);
    @(negedge clk);
    in_valid = 1'b0;
    idx      = 0;
    stall    = 0;
    cyc      = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      cyc++;
      out_ready = !(idx == 1 && stall < 5);
      if (out_valid) begin
        cur = '{out_lanes, out_sum, out_last};
        if (!out_ready) begin
          stall++;
          checks++;
          if (cur !== beat_t'({4'b1111, 3'd4, 1'b0})) begin
            failures++;
            $display("[TB] FAIL stall_hold: got %b/%0d/%b expected 1111/4/0",
                     cur.lanes, cur.sum, cur.last);
          end
        end else begin
          e = exp_q.pop_front();
          idx++;
          checks++;
          if (cur !== e) begin
            failures++;
            $display("[TB] FAIL stall_beat%0d: got %b/%0d/%b expected %b/%0d/%b",
                     idx, cur.lanes, cur.sum, cur.last, e.lanes, e.sum, e.last);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_timeout: got %0d beats left valid=%b expected 0 0",
               exp_q.size(), out_valid);
    end
    out_ready = 1'b1;
    exp_q.delete();
  endtask

  // Reset asserted after the first beat of a 12 count; out_valid must fall
  // without a clock edge, then a fresh count must work normally.
  task automatic test_reset_mid_burst();
    int g;
    @(negedge clk);
    in_valid  = 1'b1;
    in_count  = CW'(12);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_lanes !== 4'b1111 || out_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_first_beat: got valid=%b lanes=%b last=%b expected 1 1111 0",
               out_valid, out_lanes, out_last);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_lanes !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_async: got valid=%b busy=%b ready=%b lanes=%b expected 0 0 0 0000",
               out_valid, busy, in_ready, out_lanes);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prod_q.push_back(2);
    run_stream(0, 20, g);
  endtask

  task automatic test_back_to_back();
    int g;
    int exp_gaps;
    prod_q.push_back(5);
    prod_q.push_back(2);
    run_stream(0, 30, g);
`ifdef UNARY_SKID_EN
    exp_gaps = 0;
`else
    exp_gaps = 1;
`endif
    checks++;
    if (g != exp_gaps) begin
      failures++;
      $display("[TB] FAIL back_to_back_gap: got %0d idle cycles expected %0d", g, exp_gaps);
    end
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 40; i++) begin
      prod_q.push_back(int'($urandom_range(15)));
    end
    run_stream(30, 2000, g);
    for (int i = 0; i < 20; i++) begin
      prod_q.push_back(int'($urandom_range(15)));
    end
    run_stream(0, 1000, g);
  endtask

  initial begin
    test_reset();
    test_single(3);
    test_single(0);
    test_single(4);
    test_multi_beat();
    test_stall();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
